// File: rtl/vector_mem_sequencer_if.sv
// Bundles the vector request side and the scalar data-memory side of the sequencer.
// The master view is taken by the sequencer; the slave view is taken by the pipeline/memory environment.
interface vector_mem_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Vector request from the load/store address stage
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr [0:3];
    logic [DATA_W-1:0] req_data [0:3];

    // Scalar data-memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic [DATA_W-1:0] mem_rdata;

    // Writeback and pipeline control
    logic [DATA_W-1:0] load_data [0:3];
    logic              done;
    logic              stall;

    modport master (
        input  req_valid, req_we, req_addr, req_data, mem_gnt, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, load_data, done, stall
    );

    modport slave (
        output req_valid, req_we, req_addr, req_data, mem_gnt, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, load_data, done, stall
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Serialises one 4-lane vector load/store into four in-order scalar memory accesses,
// gathering load returns back into a vector and stalling the pipeline while busy.
module vector_mem_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vector_mem_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_lane;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr      [0:3];
    logic [DATA_W-1:0] r_data      [0:3];
    logic              r_pend;
    logic [1:0]        r_tag;
    logic [DATA_W-1:0] r_load_data [0:3];

    logic              w_accept;
    logic              w_grant;
    logic              w_req_ready;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_done;

    assign w_accept = (r_state == S_IDLE)  && bus.req_valid;
    assign w_grant  = (r_state == S_ISSUE) && bus.mem_gnt;

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mem_req   = 1'b1;
                w_mem_we    = r_we;
                w_mem_addr  = r_addr[r_lane];
                w_mem_wdata = r_we ? r_data[r_lane] : '0;
                if (bus.mem_gnt && (r_lane == 2'd3)) begin
                    w_next_state = r_we ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lane counter wraps 3->0 on the last grant, which leaves it at 0 for the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= 2'd0;
        end else if (w_accept) begin
            r_lane <= 2'd0;
        end else if (w_grant) begin
            r_lane <= r_lane + 2'd1;
        end
    end

    // NOTE: the small captured arrays are reset explicitly because the block
    // promises all-zero contents out of reset; large RAMs would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (w_accept) begin
            r_we <= bus.req_we;
            for (int i = 0; i < 4; i++) begin
                r_addr[i] <= bus.req_addr[i];
                r_data[i] <= bus.req_data[i];
            end
        end
    end

    // Read returns land one cycle after their grant and overlap the next lane's issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_tag  <= 2'd0;
        end else begin
            r_pend <= w_grant && !r_we;
            if (w_grant) begin
                r_tag <= r_lane;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_load_data[i] <= '0;
            end
        end else if (r_pend) begin
            r_load_data[r_tag] <= bus.mem_rdata;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.done      = w_done;
    assign bus.stall     = (r_state != S_IDLE);
    assign bus.load_data = r_load_data;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: a transaction-level model predicts the
// memory accesses, completion timing and gathered load vector; directed tests pin it with literals.
module tb_vector_mem_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic clk;
    logic rst_n;
    int   cyc;

    int n_cmp;
    int n_fail;

    vector_mem_sequencer_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    vector_mem_sequencer #(.DATA_W(32), .ADDR_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image: a few preloaded words, everything else a recognisable function of the address.
    logic [31:0] mem_img [int unsigned];

    function automatic logic [31:0] mem_value(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory responder: grants unless a denial is budgeted for deny_addr, returns read data one cycle later.
    logic [31:0] deny_addr;
    int          deny_budget;
    int          deny_spent;

    initial begin
        logic        rd_pend;
        logic [31:0] rd_addr;
        rd_pend       = 1'b0;
        rd_addr       = '0;
        deny_spent    = 0;
        bus.mem_gnt   = 1'b1;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rdata = rd_pend ? mem_value(rd_addr) : 32'hDEAD_BEEF;
            bus.mem_gnt   = !((deny_spent < deny_budget) && bus.mem_req && (bus.mem_addr == deny_addr));
            @(negedge clk);
            rd_pend = rst_n && bus.mem_req && bus.mem_gnt && !bus.mem_we;
            rd_addr = bus.mem_addr;
            if (rst_n && bus.mem_req && !bus.mem_gnt) deny_spent++;
        end
    end

    // Transaction-level model, evaluated mid-cycle on every cycle.
    logic        m_busy;
    logic        m_we;
    logic [31:0] m_addr [4];
    acc_t        m_q [$];
    int          m_tail;
    logic [31:0] m_load [4];
    int          accept_count;
    int          done_count;
    int          accept_cyc;
    int          done_cyc;

    task automatic check_quiet_mem(input string tag);
        check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    endtask

    task automatic check_load_vec(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_load_data[%0d]", tag, i), bus.load_data[i], m_load[i]);
        end
    endtask

    initial begin
        m_busy       = 1'b0;
        m_we         = 1'b0;
        m_tail       = 0;
        accept_count = 0;
        done_count   = 0;
        accept_cyc   = 0;
        done_cyc     = 0;
        for (int i = 0; i < 4; i++) begin
            m_load[i] = '0;
            m_addr[i] = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_q.delete();
            for (int i = 0; i < 4; i++) m_load[i] = '0;
            check("rst_req_ready", 32'(bus.req_ready), 32'd1);
            check("rst_stall",     32'(bus.stall),     32'd0);
            check("rst_done",      32'(bus.done),      32'd0);
            check_quiet_mem("rst");
            check_load_vec("rst");
        end else if (!m_busy) begin
            check("idle_req_ready", 32'(bus.req_ready), 32'd1);
            check("idle_stall",     32'(bus.stall),     32'd0);
            check("idle_done",      32'(bus.done),      32'd0);
            check_quiet_mem("idle");
            check_load_vec("idle");
            if (bus.req_valid) begin
                m_busy = 1'b1;
                m_we   = bus.req_we;
                m_tail = bus.req_we ? 1 : 2;
                for (int i = 0; i < 4; i++) begin
                    m_addr[i] = bus.req_addr[i];
                    m_q.push_back('{addr: bus.req_addr[i], data: bus.req_we ? bus.req_data[i] : 32'd0});
                end
                accept_cyc = cyc;
                accept_count++;
            end
        end else begin
            check("busy_req_ready", 32'(bus.req_ready), 32'd0);
            check("busy_stall",     32'(bus.stall),     32'd1);
            if (m_q.size() > 0) begin
                check("issue_mem_req",   32'(bus.mem_req), 32'd1);
                check("issue_mem_we",    32'(bus.mem_we),  32'(m_we));
                check("issue_mem_addr",  bus.mem_addr,     m_q[0].addr);
                check("issue_mem_wdata", bus.mem_wdata,    m_q[0].data);
                check("issue_done",      32'(bus.done),    32'd0);
                if (bus.mem_gnt) void'(m_q.pop_front());
            end else if (m_tail == 2) begin
                check("drain_done", 32'(bus.done), 32'd0);
                check_quiet_mem("drain");
                m_tail = 1;
            end else begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check_quiet_mem("done");
                if (!m_we) begin
                    for (int i = 0; i < 4; i++) m_load[i] = mem_value(m_addr[i]);
                end
                check_load_vec("done");
                done_cyc = cyc;
                done_count++;
                m_busy = 1'b0;
            end
        end
    end

    function automatic logic [3:0][31:0] ramp(input logic [31:0] base);
        logic [3:0][31:0] v;
        for (int i = 0; i < 4; i++) v[i] = base + 32'(i);
        return v;
    endfunction

    task automatic start_op(input logic we, input logic [3:0][31:0] a, input logic [3:0][31:0] d);
        int a0;
        int n;
        a0 = accept_count;
        bus.req_we = we;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i] = a[i];
            bus.req_data[i] = d[i];
        end
        bus.req_valid = 1'b1;
        n = 0;
        while (accept_count == a0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_seen", 32'(accept_count), 32'(a0 + 1));
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_count == d0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 32'(done_count), 32'(d0 + 1));
    endtask

    task automatic check_reset_now();
        check("async_rst_mem_req",   32'(bus.mem_req),   32'd0);
        check("async_rst_mem_addr",  bus.mem_addr,       32'd0);
        check("async_rst_done",      32'(bus.done),      32'd0);
        check("async_rst_stall",     32'(bus.stall),     32'd0);
        check("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("async_rst_load_data[%0d]", i), bus.load_data[i], 32'd0);
        end
    endtask

    initial begin
        int d0;
        int a0;
        int n;
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        mem_img[32'h40] = 32'h11;
        mem_img[32'h41] = 32'h22;
        mem_img[32'h42] = 32'h33;
        mem_img[32'h43] = 32'h44;
        deny_addr     = '0;
        deny_budget   = 0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i] = '0;
            bus.req_data[i] = '0;
        end

        // Power-on reset asserted between clock edges
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_now();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store, zero-wait grants: done 5 cycles after accept
        d0 = done_count;
        start_op(1'b1, ramp(32'h100), ramp(32'hA0));
        wait_done(d0);
        check("store_latency", 32'(done_cyc - accept_cyc), 32'd5);
        check("store_keeps_load_data0", bus.load_data[0], 32'd0);

        // Load, zero-wait grants: done 6 cycles after accept
        d0 = done_count;
        start_op(1'b0, ramp(32'h40), ramp(32'hFF));
        wait_done(d0);
        check("load_latency", 32'(done_cyc - accept_cyc), 32'd6);
        check("load_lane0", bus.load_data[0], 32'h11);
        check("load_lane1", bus.load_data[1], 32'h22);
        check("load_lane2", bus.load_data[2], 32'h33);
        check("load_lane3", bus.load_data[3], 32'h44);

        // Load with two refused grants on lane 1
        deny_addr   = 32'h81;
        deny_budget = deny_budget + 2;
        d0 = done_count;
        start_op(1'b0, ramp(32'h80), ramp(32'h0));
        wait_done(d0);
        check("deny_latency", 32'(done_cyc - accept_cyc), 32'd8);
        check("deny_lane0", bus.load_data[0], 32'hC0DE_0080);
        check("deny_lane1", bus.load_data[1], 32'hC0DE_0081);
        check("deny_lane3", bus.load_data[3], 32'hC0DE_0083);

        // Reset while lane 2 is on the memory port
        d0 = done_count;
        start_op(1'b0, ramp(32'h200), ramp(32'h0));
        n = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h202) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lane2_reached", 32'(n < 20), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_now();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_count), 32'(d0));

        // Fresh store after reset completes normally and leaves load_data cleared
        d0 = done_count;
        start_op(1'b1, ramp(32'h300), ramp(32'hC0));
        wait_done(d0);
        check("post_rst_latency", 32'(done_cyc - accept_cyc), 32'd5);
        check("post_rst_load_data2", bus.load_data[2], 32'd0);

        // Back-to-back: request held high, alternating store/load
        a0 = accept_count;
        d0 = done_count;
        bus.req_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i] = 32'h500 + 32'(i);
            bus.req_data[i] = 32'hB0 + 32'(i);
        end
        bus.req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (accept_count == a0 + k && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("b2b_accept", 32'(accept_count), 32'(a0 + k + 1));
            if (k > 0) check("b2b_gap", 32'(accept_cyc - done_cyc), 32'd1);
            bus.req_we = (k % 2 == 1);
            for (int i = 0; i < 4; i++) begin
                bus.req_addr[i] = 32'h600 + 32'(k * 256 + i);
                bus.req_data[i] = 32'hD0 + 32'(k * 16 + i);
            end
            if (k == 3) bus.req_valid = 1'b0;
        end
        n = 0;
        while (done_count < d0 + 4 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_all_done", 32'(done_count), 32'(d0 + 4));
        repeat (3) @(posedge clk);
        #1;
        check("b2b_no_extra_accept", 32'(accept_count), 32'(a0 + 4));
        check("b2b_final_lane0", bus.load_data[0], 32'hC0DE_0800);
        check("b2b_final_lane3", bus.load_data[3], 32'hC0DE_0803);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Serialises one 4-lane vector memory operation into four single-word accesses on the scalar data-memory port. It sits directly downstream of the vector load/store address stage and consumes that stage's per-lane addresses and store data. For loads, it gathers the four returned words back into a vector for writeback. While an operation is in flight it holds a stall to the pipeline.

## Interface
Parameters:
- DATA_W, 32, lane data width
- ADDR_W, 32, address width (word addresses, passed through unmodified)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  vector operation request
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready
- req_we  in  1  1 = vector store, 0 = vector load
- req_addr [0:3]  in  ADDR_W  per-lane word addresses
- req_data [0:3]  in  DATA_W  per-lane store data (ignored for loads)
- mem_req  out  1  memory access request
- mem_we  out  1  write enable for the current access
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_gnt  in  1  memory accepts the access this cycle (sampled only when mem_req=1)
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a granted read
- load_data [0:3]  out  DATA_W  gathered load result
- done  out  1  one-cycle completion pulse
- stall  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. 2-bit lane counter. Captured registers: we_q, addr_q[0:3], data_q[0:3].
- IDLE: req_ready=1. On accept, capture req_we/req_addr/req_data, lane=0, go to ISSUE. req_valid outside IDLE is ignored, not queued.
- ISSUE: mem_req=1, mem_we=we_q, mem_addr=addr_q[lane], mem_wdata=data_q[lane] (0 when we_q=0).
  - mem_gnt=0: hold all outputs and lane.
  - mem_gnt=1 and lane<3: lane+1.
  - mem_gnt=1 and lane=3: go to DONE if store, DRAIN if load.
- Read return: a registered pending flag and lane tag are set on every granted read. In the following cycle, mem_rdata is written to load_data[tag]. Returns overlap with issue of the next lane.
- DRAIN: mem_req=0. Captures the lane-3 return, then goes to DONE.
- DONE: done=1, mem_req=0, req_ready=0. Next state is IDLE.
- load_data holds its value until overwritten by the next load. Stores never modify it.
- When mem_req=0, mem_we, mem_addr and mem_wdata are 0.
- Address arithmetic is none; no lane reordering; lanes always issue in order 0..3.

## Timing
- Reset (async assert): state=IDLE, lane=0, pending=0, all captured registers 0, load_data all 0, mem_req=0, done=0, stall=0, req_ready=1. Effect is immediate, not clock-gated.
- Reset mid-operation: the access in flight is abandoned and any outstanding read return is discarded. It is the memory side's responsibility to tolerate this.
- Accept in cycle T, with zero-wait grants:
  - lanes issue T+1..T+4.
  - Store: done in T+5, req_ready in T+6.
  - Load: lane-3 data captured at end of T+5 (DRAIN), done in T+6, req_ready in T+7.
  - load_data is fully valid in the done cycle.
- Each cycle with mem_gnt=0 during ISSUE adds exactly one cycle to the latency.
- stall rises in T+1 and falls when IDLE is re-entered.
- Back-to-back: a request held high is accepted in the first IDLE cycle after DONE.

## Test plan
- Reset: with rst_n low asynchronously mid-cycle, all outputs must go to their reset values immediately, with req_ready=1.
- Store with zero-wait grants: addr 0x100..0x103, data 0xA0..0xA3.
  - Required: mem_req high T+1..T+4, mem_we=1, mem_addr/mem_wdata lane pairs in order.
  - Required: done at T+5; load_data unchanged.
- Load with zero-wait grants: addr 0x40..0x43, memory returns 0x11,0x22,0x33,0x44.
  - Required: mem_we=0, load_data = {0x11,0x22,0x33,0x44} at the done cycle T+6.
- Load with mem_gnt low for 2 cycles on lane 1.
  - Required: mem_addr held at lane-1 address, done at T+8, correct lane placement.
- Reset asserted during ISSUE lane 2.
  - Required: mem_req drops at once, no done pulse, load_data=0.
  - Required: a fresh request after deassertion completes normally.
- req_valid held high continuously with alternating store/load.
  - Required: exactly one accept per operation, in the IDLE cycle after each done.
  - Required: stall continuously high except in that IDLE cycle.
